demux_deser8: RTL and testbench
===============================

DEMUX_DESER8 -- requirements
Module: demux_deser8

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the parallel word width; the legal range is 2..16.
REQ-002 SHALL have parameter MSB_FIRST, default 1: 1 means the first serial bit lands in pout[WIDTH-1]; 0 means it lands in pout[0].
REQ-003 SHALL have port clk, input, 1 bit: the single rising-edge clock.
REQ-004 SHALL have port rst, input, 1 bit: reset. One clock; reset is synchronous and active-high.
REQ-005 SHALL have port clr, input, 1 bit: synchronous discard of any partial word.
REQ-006 SHALL have port sin, input, 1 bit: serial data bit.
REQ-007 SHALL have port sin_valid, input, 1 bit: sin carries a bit this cycle.
REQ-008 SHALL have port sin_ready, output, 1 bit: the block accepts a bit this cycle.
REQ-009 SHALL have port pout, output, WIDTH bits: the assembled parallel word.
REQ-010 SHALL have port pout_valid, output, 1 bit: pout holds a complete word.
REQ-011 SHALL have port pout_ready, input, 1 bit: the consumer takes the word this cycle.
REQ-012 SHALL have port bit_cnt, output, clog2(WIDTH)+1 bits: the number of bits held in the current partial word.

Function
REQ-013 SHALL transfer a serial bit only on a clock edge where sin_valid and sin_ready are both 1.
REQ-014 SHALL transfer a word only on a clock edge where pout_valid and pout_ready are both 1.
REQ-015 SHALL implement a two-state FSM with states COLLECT and FULL.
REQ-016 In COLLECT: sin_ready=1 and pout_valid=0.
REQ-017 In FULL: pout_valid=1, and sin_ready equals pout_ready combinationally.
REQ-018 SHALL route each accepted bit through a counter-driven 1-to-WIDTH demux into bit position bit_cnt (MSB_FIRST=0) or position WIDTH-1-bit_cnt (MSB_FIRST=1).
REQ-019 Once a word bit is written it SHALL be held until the word is consumed.
REQ-020 Accepting a bit in COLLECT SHALL increment bit_cnt.
REQ-021 When the WIDTH-th bit is accepted, the FSM SHALL go to FULL on that same edge, so pout_valid=1 in the next cycle, and bit_cnt SHALL read WIDTH.
REQ-022 Latency SHALL be exactly one cycle from acceptance of the last bit to pout_valid=1.
REQ-023 pout SHALL stay stable while pout_valid=1 and pout_ready=0 (back-pressure).
REQ-024 In FULL with pout_ready=1 and sin_valid=0: the FSM SHALL go to COLLECT and bit_cnt SHALL go to 0.
REQ-025 In FULL with pout_ready=1 and sin_valid=1: the word SHALL be consumed and the new bit SHALL be written as the first bit of the next word, with bit_cnt=1 and the FSM in COLLECT. This gives zero-bubble streaming.
REQ-026 Bit positions not yet written in the next word SHALL read 0; the word register is cleared when a word is consumed.
REQ-027 clr in COLLECT SHALL zero bit_cnt and the word register; a bit presented in the same cycle SHALL be dropped even though sin_ready=1.
REQ-028 clr in FULL SHALL NOT drop the completed word. Any bit accepted in that cycle (per REQ-025) SHALL be discarded, leaving bit_cnt=0.
REQ-029 rst SHALL take priority over clr and over all handshakes.

Reset
REQ-030 While rst=1 at a clock edge, the block SHALL enter COLLECT with bit_cnt=0, pout=0, pout_valid=0 and sin_ready=1 from the next cycle.
REQ-031 Reset mid-word or in FULL SHALL discard all data without emitting a word.
REQ-032 No output SHALL depend on any state that rst does not initialize.

Structure
REQ-033 A shared package SHALL hold the FSM state encoding (COLLECT=1'b0, FULL=1'b1) and the bit_cnt width function.
REQ-034 The per-bit demux SHALL be a single sub-module, demux1x8_en. It takes inputs d, en and sel[2:0] and has output o[7:0], with each output high only when en=1 and sel selects it. For WIDTH≠8 it is generalized by a width parameter.
REQ-035 Outputs pout, pout_valid and bit_cnt SHALL be driven directly from registers. Only sin_ready may be combinational.

Verification
REQ-036 Reset, then 8 bits 1,0,1,1,0,0,1,0 with sin_valid=1, MSB_FIRST=1, pout_ready=1 -> pout=8'hB2 with pout_valid=1 in the cycle after the 8th bit, and for exactly one cycle.
REQ-037 Same stream with MSB_FIRST=0 -> pout=8'h4D.
REQ-038 Back-pressure: hold pout_ready=0 for 5 cycles after a complete word 8'hA5 -> pout stays 8'hA5, sin_ready=0 throughout, and no bits are lost once pout_ready=1.
REQ-039 Continuous stream of 3 words 8'h01, 8'hFF, 8'h3C with pout_ready=1 throughout -> three pout_valid pulses exactly 8 cycles apart, with sin_ready never 0.
REQ-040 Assert clr after 5 bits of a word, then send 8 fresh bits of 8'h81 -> pout=8'h81, with none of the first 5 bits present.
REQ-041 Assert rst in FULL and mid-word -> pout_valid=0, bit_cnt=0 and pout=0 in the next cycle; a following full word decodes correctly.

Source files
------------

// File: rtl/demux_deser8_pkg.sv
// Shared FSM encoding and width helpers for the serial-to-parallel deserializer.
package demux_deser8_pkg;

  localparam logic [0:0] ST_COLLECT = 1'b0;
  localparam logic [0:0] ST_FULL    = 1'b1;

  // bit_cnt must be able to hold the value WIDTH itself, hence the extra bit.
  function automatic int cnt_w(input int width);
    return $clog2(width) + 1;
  endfunction

  function automatic int sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/demux_deser8_demux.sv
// Enabled 1-to-N demux: d appears on the selected output only while en is high.
// Purely combinational, no flow control.
module demux1x8_en #(
  parameter int N  = 8,
  parameter int SW = 3
) (
  input  logic          d,
  input  logic          en,
  input  logic [SW-1:0] sel,
  output logic [N-1:0]  o
);

  always_comb begin
    o = '0;
    if (en) begin
      for (int i = 0; i < N; i++) begin
        if (sel == SW'(i)) o[i] = d;
      end
    end
  end

endmodule

// File: rtl/demux_deser8.sv
// Serial-to-parallel deserializer: one cycle from last accepted bit to pout_valid.
// While a word is waiting, sin_ready follows pout_ready so input stalls with the consumer.
module demux_deser8
  import demux_deser8_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    sin,
  input  logic                    sin_valid,
  output logic                    sin_ready,
  output logic [WIDTH-1:0]        pout,
  output logic                    pout_valid,
  input  logic                    pout_ready,
  output logic [cnt_w(WIDTH)-1:0] bit_cnt
);

  localparam int CW = cnt_w(WIDTH);
  localparam int SW = sel_w(WIDTH);

  logic [0:0]       state;
  logic [CW-1:0]    slot;
  logic [SW-1:0]    sel;
  logic [WIDTH-1:0] hot;
  logic             take;

  assign sin_ready  = (state == ST_COLLECT) | pout_ready;
  assign pout_valid = state[0];
  // A bit arriving with clr is never written, even though the handshake completes.
  assign take       = sin_valid & sin_ready & ~clr;

  // While FULL, an accepted bit starts the next word, so it goes to slot 0.
  always_comb begin
    slot = (state == ST_FULL) ? '0 : bit_cnt;
    sel  = MSB_FIRST ? SW'(CW'(WIDTH - 1) - slot) : SW'(slot);
  end

  demux1x8_en #(
    .N  (WIDTH),
    .SW (SW)
  ) u_demux (
    .d   (sin),
    .en  (take),
    .sel (sel),
    .o   (hot)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_COLLECT;
      bit_cnt <= '0;
      pout    <= '0;
    end else if (state == ST_COLLECT) begin
      if (clr) begin
        bit_cnt <= '0;
        pout    <= '0;
      end else if (sin_valid) begin
        pout <= pout | hot;
        if (bit_cnt == CW'(WIDTH - 1)) begin
          state   <= ST_FULL;
          bit_cnt <= CW'(WIDTH);
        end else begin
          bit_cnt <= bit_cnt + CW'(1);
        end
      end
    end else if (pout_ready) begin
      // Consuming the word clears the register; hot is zero unless a bit was taken.
      state   <= ST_COLLECT;
      pout    <= hot;
      bit_cnt <= take ? CW'(1) : '0;
    end
  end

endmodule

// File: tb/tb_demux_deser8.sv
// Bench for demux_deser8: MSB-first and LSB-first instances share one stimulus stream.
module tb_demux_deser8;

  localparam int W = 8;

  logic       clk = 1'b0;
  logic       rst, clr, sin, sin_valid, pout_ready;
  logic       rdy_m, rdy_l, pv_m, pv_l;
  logic [7:0] pout_m, pout_l;
  logic [3:0] cnt_m, cnt_l;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  bit         m_full = 1'b0;
  bit         m_bits[$];
  int         pulses[$];
  logic [7:0] dut_words[$];
  bit         saw_rdy_low;
  logic       last_rdy_m;

  always #5 clk = ~clk;

  demux_deser8 #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .clr(clr), .sin(sin), .sin_valid(sin_valid),
    .sin_ready(rdy_m), .pout(pout_m), .pout_valid(pv_m),
    .pout_ready(pout_ready), .bit_cnt(cnt_m)
  );

  demux_deser8 #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .clr(clr), .sin(sin), .sin_valid(sin_valid),
    .sin_ready(rdy_l), .pout(pout_l), .pout_valid(pv_l),
    .pout_ready(pout_ready), .bit_cnt(cnt_l)
  );

  // Word value implied by the bits collected so far, in arrival order.
  function automatic logic [7:0] assemble(input bit msb);
    int v = 0;
    foreach (m_bits[k]) if (m_bits[k]) v += 1 << (msb ? (W - 1 - k) : k);
    return 8'(v);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_regs();
    int n;
    n = m_full ? W : m_bits.size();
    chk("pv_msb",   32'(pv_m),   32'(m_full));
    chk("pv_lsb",   32'(pv_l),   32'(m_full));
    chk("cnt_msb",  32'(cnt_m),  32'(n));
    chk("cnt_lsb",  32'(cnt_l),  32'(n));
    chk("pout_msb", 32'(pout_m), 32'(assemble(1'b1)));
    chk("pout_lsb", 32'(pout_l), 32'(assemble(1'b0)));
  endtask

  // One clock: entered and left at a falling edge.
  task automatic cycle(input logic r, input logic c, input logic sv, input logic s, input logic pr);
    rst = r; clr = c; sin_valid = sv; sin = s; pout_ready = pr;
    #1;
    chk("rdy_msb", 32'(rdy_m), 32'(!m_full || pr));
    chk("rdy_lsb", 32'(rdy_l), 32'(!m_full || pr));
    last_rdy_m = rdy_m;
    if (rdy_m !== 1'b1) saw_rdy_low = 1'b1;
    @(posedge clk);
    if (r) begin
      m_bits.delete(); m_full = 1'b0;
    end else if (!m_full) begin
      if (c) m_bits.delete();
      else if (sv) begin
        m_bits.push_back(s);
        if (m_bits.size() == W) m_full = 1'b1;
      end
    end else if (pr) begin
      m_bits.delete(); m_full = 1'b0;
      if (sv && !c) m_bits.push_back(s);
    end
    @(negedge clk);
    cyc++;
    if (pv_m === 1'b1) begin
      pulses.push_back(cyc);
      dut_words.push_back(pout_m);
    end
    check_regs();
  endtask

  task automatic send_word(input logic [7:0] w, input logic pr);
    for (int i = 0; i < W; i++) cycle(1'b0, 1'b0, 1'b1, w[W-1-i], pr);
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; sin = 1'b0; sin_valid = 1'b0; pout_ready = 1'b0;
    saw_rdy_low = 1'b0;
    @(negedge clk);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    chk("reset_pout", 32'(pout_m), 32'h0);
    chk("reset_cnt",  32'(cnt_m),  32'h0);
    chk("reset_pv",   32'(pv_m),   32'h0);

    // Basic stream 1,0,1,1,0,0,1,0 in both bit orders.
    send_word(8'hB2, 1'b1);
    chk("b2_pout_msb", 32'(pout_m), 32'hB2);
    chk("4d_pout_lsb", 32'(pout_l), 32'h4D);
    chk("b2_pv",       32'(pv_m),   32'h1);
    chk("b2_cnt",      32'(cnt_m),  32'h8);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("b2_one_cycle", 32'(pv_m),  32'h0);
    chk("b2_cleared",   32'(pout_m), 32'h0);

    // Back-pressure on A5, then the held bit lands as first bit of C3.
    send_word(8'hA5, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      chk("bp_hold",  32'(pout_m),     32'hA5);
      chk("bp_rdy0",  32'(last_rdy_m), 32'h0);
    end
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    chk("bp_restart_cnt", 32'(cnt_m), 32'h1);
    for (int i = 1; i < W; i++) cycle(1'b0, 1'b0, 1'b1, 1'(8'hC3 >> (W - 1 - i)), 1'b1);
    chk("bp_next_word", 32'(pout_m), 32'hC3);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Zero-bubble stream of three words.
    pulses.delete(); dut_words.delete(); saw_rdy_low = 1'b0;
    send_word(8'h01, 1'b1);
    send_word(8'hFF, 1'b1);
    send_word(8'h3C, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("stream_pulses", 32'(pulses.size()), 32'd3);
    if (pulses.size() == 3) begin
      chk("stream_gap1", 32'(pulses[1] - pulses[0]), 32'd8);
      chk("stream_gap2", 32'(pulses[2] - pulses[1]), 32'd8);
      chk("stream_w0", 32'(dut_words[0]), 32'h01);
      chk("stream_w1", 32'(dut_words[1]), 32'hFF);
      chk("stream_w2", 32'(dut_words[2]), 32'h3C);
    end
    chk("stream_rdy_never_low", 32'(saw_rdy_low), 32'h0);

    // clr after five bits; bit presented with clr is dropped.
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    chk("clr_cnt",  32'(cnt_m),  32'h0);
    chk("clr_pout", 32'(pout_m), 32'h0);
    send_word(8'h81, 1'b1);
    chk("clr_word", 32'(pout_m), 32'h81);

    // clr in FULL: held word survives stall, then consumed with bit discarded.
    cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("clr_full_keep", 32'(pout_m), 32'h81);
    chk("clr_full_pv",   32'(pv_m),   32'h1);
    cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    chk("clr_full_cnt", 32'(cnt_m), 32'h0);

    // Reset in FULL and mid-word.
    send_word(8'h5A, 1'b0);
    cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("rst_full_pv",   32'(pv_m),   32'h0);
    chk("rst_full_pout", 32'(pout_m), 32'h0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("rst_mid_cnt",  32'(cnt_m),  32'h0);
    chk("rst_mid_pout", 32'(pout_m), 32'h0);
    send_word(8'h6E, 1'b1);
    chk("rst_after_word", 32'(pout_m), 32'h6E);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Random traffic against the queue model.
    for (int i = 0; i < 600; i++) begin
      cycle(1'($urandom_range(0, 79) == 0), 1'($urandom_range(0, 24) == 0),
            1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom_range(0, 2) != 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
